// File: rtl/fmap_readout.sv
// Drains a feature-map BRAM one word at a time and streams it out LSB byte first over valid/ready.
// Optional FMAP_RD_CKSUM_EN appends a 16-bit byte-sum trailer (low byte, then high byte).
module fmap_readout #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | bram_en high for the current word address
    // WAIT  | BRAM read latency; word captured at end of cycle
    // SHIFT | presenting payload bytes, LSB first
    // TRAIL | presenting checksum low/high byte (FMAP_RD_CKSUM_EN only)
    // DONE  | one-cycle completion pulse
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NB - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
`ifdef FMAP_RD_CKSUM_EN
    localparam bit PAY_LAST = 1'b0;
`else
    localparam bit PAY_LAST = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
`ifdef FMAP_RD_CKSUM_EN
        S_TRAIL,
`endif
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W:0]    remaining;
    logic [DATA_W-1:0]  shift_reg, shift_nxt;
    logic [IDX_W-1:0]   idx, idx_inc;
    logic               hs, byte_last, last_word, stream_nxt;
`ifdef FMAP_RD_CKSUM_EN
    logic [15:0]        cksum, cksum_nxt;
    logic               tidx;
`endif

    always_comb begin
        hs         = m_valid & m_ready;
        byte_last  = (idx == IDX_LAST);
        last_word  = (remaining == CNT_ONE);
        idx_inc    = idx + IDX_ONE;
        shift_nxt  = shift_reg >> 8;
`ifdef FMAP_RD_CKSUM_EN
        cksum_nxt  = cksum + {8'd0, m_data};
`endif
        state_nxt  = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (word_cnt == '0) ? S_DONE : S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (hs && byte_last) begin
                    if (last_word) begin
`ifdef FMAP_RD_CKSUM_EN
                        state_nxt = S_TRAIL;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
`ifdef FMAP_RD_CKSUM_EN
            S_TRAIL: if (hs && tidx) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
`ifdef FMAP_RD_CKSUM_EN
        stream_nxt = (state_nxt == S_SHIFT) || (state_nxt == S_TRAIL);
`else
        stream_nxt = (state_nxt == S_SHIFT);
`endif
    end

    // Every output is a flop loaded from next-state decode, so m_ready never reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            remaining <= '0;
            shift_reg <= '0;
            idx       <= '0;
`ifdef FMAP_RD_CKSUM_EN
            cksum     <= '0;
            tidx      <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done    <= (state_nxt == S_DONE);
            bram_en <= (state_nxt == S_FETCH);
            m_valid <= stream_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bram_addr <= base_addr;
                        remaining <= word_cnt;
`ifdef FMAP_RD_CKSUM_EN
                        cksum     <= '0;
                        tidx      <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    shift_reg <= bram_dout;
                    idx       <= '0;
                    m_data    <= bram_dout[7:0];
                    m_last    <= PAY_LAST && last_word && (IDX_LAST == '0);
                end
                S_SHIFT: begin
                    if (hs) begin
`ifdef FMAP_RD_CKSUM_EN
                        cksum <= cksum_nxt;
`endif
                        if (byte_last) begin
                            remaining <= remaining - CNT_ONE;
                            bram_addr <= bram_addr + ADDR_ONE;
                            m_last    <= 1'b0;
`ifdef FMAP_RD_CKSUM_EN
                            if (last_word) m_data <= cksum_nxt[7:0];
`endif
                        end else begin
                            idx       <= idx_inc;
                            shift_reg <= shift_nxt;
                            m_data    <= shift_nxt[7:0];
                            m_last    <= PAY_LAST && last_word && (idx_inc == IDX_LAST);
                        end
                    end
                end
`ifdef FMAP_RD_CKSUM_EN
                S_TRAIL: begin
                    if (hs) begin
                        if (!tidx) begin
                            tidx   <= 1'b1;
                            m_data <= cksum[15:8];
                            m_last <= 1'b1;
                        end else begin
                            m_last <= 1'b0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_readout.sv
// Bench for fmap_readout: vector table plus random jobs, all checked against a byte-queue model of the stream.
module tb_fmap_readout;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;
`ifdef FMAP_RD_CKSUM_EN
    localparam int TRAILB = 2;
`else
    localparam int TRAILB = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_cnt = '0;
    logic              busy, done, bram_en, m_valid, m_last;
    logic              m_ready = 1'b1;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic [7:0]        m_data;

    always #5 clk = ~clk;

    fmap_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
        .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference stream: bytes in address order, LSB first, optional sum trailer, last flag on final element.
    logic [7:0]        exp_d[$];
    bit                exp_l[$];
    logic [ADDR_W-1:0] exp_a[$];
    logic [7:0]        got_q[$];
    int  first_v_cyc, done_cyc, done_cnt;
    bit  first_seen;
    int  ready_mode = 0;

    task automatic build_model(logic [ADDR_W-1:0] b, int n);
        logic [15:0] sum = '0;
        exp_d.delete(); exp_l.delete(); exp_a.delete(); got_q.delete();
        for (int w = 0; w < n; w++) begin
            logic [ADDR_W-1:0] a = b + ADDR_W'(w);
            logic [63:0] word = mem[a];
            exp_a.push_back(a);
            for (int k = 0; k < DATA_W / 8; k++) begin
                logic [7:0] by = word[8*k +: 8];
                exp_d.push_back(by);
                exp_l.push_back(1'b0);
                sum = sum + {8'd0, by};
            end
        end
`ifdef FMAP_RD_CKSUM_EN
        if (n > 0) begin
            exp_d.push_back(sum[7:0]);  exp_l.push_back(1'b0);
            exp_d.push_back(sum[15:8]); exp_l.push_back(1'b0);
        end
`endif
        if (exp_l.size() > 0) exp_l[exp_l.size()-1] = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = (ready_mode == 0) ? 1'b1 : (($urandom % 3) != 0);
    end

    initial begin : monitor
        logic pv, pr, pl;
        logic [7:0] pd;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv && !pr) check("stall_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, pl, pd}));
                if (bram_en) begin
                    if (exp_a.size() == 0) check("bram_en_unexpected", 64'(bram_addr), 64'hDEAD);
                    else check("bram_addr", 64'(bram_addr), 64'(exp_a.pop_front()));
                end
                if (m_valid && !first_seen) begin first_seen = 1'b1; first_v_cyc = cyc; end
                if (m_valid && m_ready) begin
                    if (exp_d.size() == 0) check("byte_unexpected", 64'(m_data), 64'hDEAD);
                    else begin
                        check("m_data", 64'(m_data), 64'(exp_d.pop_front()));
                        check("m_last", 64'(m_last), 64'(exp_l.pop_front()));
                        got_q.push_back(m_data);
                    end
                end
                if (done) begin done_cnt++; done_cyc = cyc; end
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
        end
    end

    task automatic run_job(logic [ADDR_W-1:0] b, logic [ADDR_W:0] n, int mode, bit extra,
                           int exp_bytes, int exp_lat);
        int sc;
        ready_mode = mode;
        build_model(b, int'(n));
        first_seen = 1'b0;
        done_cnt   = 0;
        @(negedge clk);
        start = 1'b1; base_addr = b; word_cnt = n;
        @(negedge clk);
        start = 1'b0; base_addr = ADDR_W'($urandom); word_cnt = (ADDR_W+1)'($urandom);
        sc = cyc;
        #1;
        check("busy_after_start", 64'(busy), 64'(n != 0));
        if (extra) begin
            repeat (3) @(negedge clk);
            start = 1'b1; base_addr = 12'h7A0; word_cnt = 13'd1;
            @(negedge clk);
            start = 1'b0;
            #1;
        end
        for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("done_seen", 64'(done_cnt), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        if (exp_lat >= 0) check("done_latency", 64'(done_cyc - sc), 64'(exp_lat));
        if (exp_lat > 0) check("first_valid_lat", 64'(first_v_cyc - sc), 64'd2);
        check("byte_count", 64'(got_q.size()), 64'(exp_bytes));
        check("queue_drained", 64'(exp_d.size() + exp_a.size()), 64'd0);
        @(negedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        if (n == 0) check("no_valid_cnt0", 64'(first_seen), 64'd0);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   cnt;
        int                mode;
        bit                extra;
        int                exp_bytes;
        int                exp_lat;
    } vec_t;

    vec_t vt[6];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {$urandom, $urandom};
        mem[12'h010] = 64'h0807060504030201;
        mem[12'h300] = 64'hFFFFFFFFFFFFFFFF;

        vt[0] = '{12'h010, 13'd1, 0, 1'b0, 8 + TRAILB, 10 + TRAILB};
        vt[1] = '{12'h010, 13'd1, 1, 1'b0, 8 + TRAILB, -1};
        vt[2] = '{12'hFFF, 13'd2, 0, 1'b0, 16 + TRAILB, 20 + TRAILB};
        vt[3] = '{12'h123, 13'd0, 0, 1'b0, 0, 0};
        vt[4] = '{12'h040, 13'd3, 0, 1'b1, 24 + TRAILB, 30 + TRAILB};
        vt[5] = '{12'hFFE, 13'd4, 1, 1'b0, 32 + TRAILB, -1};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_values", 64'({busy, done, bram_en, bram_addr, m_data, m_valid, m_last}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_job(vt[i].base, vt[i].cnt, vt[i].mode, vt[i].extra, vt[i].exp_bytes, vt[i].exp_lat);
            if (i < 2) begin
                for (int k = 0; k < 8; k++) check("word010_byte", 64'(got_q[k]), 64'(k + 1));
            end
        end

        // Abandon a cnt=2 run with reset while the 4th byte is on the bus.
        ready_mode = 0;
        build_model(12'h100, 2);
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 12'h100; word_cnt = 13'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && got_q.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        check("reached_4th_byte", 64'(got_q.size()), 64'd4);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({busy, done, bram_en, bram_addr, m_data, m_valid, m_last}), 64'd0);
        exp_d.delete(); exp_l.delete(); exp_a.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("no_done_after_reset", 64'(done_cnt), 64'd0);
        run_job(12'h200, 13'd1, 0, 1'b0, 8 + TRAILB, 10 + TRAILB);

`ifdef FMAP_RD_CKSUM_EN
        run_job(12'h300, 13'd1, 0, 1'b0, 10, 12);
        check("cksum_low", 64'(got_q[8]), 64'hF8);
        check("cksum_high", 64'(got_q[9]), 64'h07);
`endif

        for (int r = 0; r < 8; r++) begin
            logic [ADDR_W:0] n;
            n = (ADDR_W+1)'($urandom_range(1, 3));
            run_job(ADDR_W'($urandom), n, 1, 1'b0, 8 * int'(n) + TRAILB, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
